fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage pipelined MIPS core; sits directly upstream of the IF/ID pipeline register.
- Owns the PC register and the icache request interface.
- Buffers a returned instruction across pipeline stalls.
- Applies branch/jump redirects and drives the IF/ID write-enable and flush controls: ifinstr, ifJALjump_addr, ifW, ifRST.

---
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 5-stage pipelined MIPS core.
// It owns the PC and the icache request interface. A returned instruction
// is buffered while the pipeline is stalled. Branch and jump redirects are
// applied here, along with the IF/ID write-enable and flush controls.
//
// Ports:
//   CLK, nRST          clock (rising edge), asynchronous active-low reset
//   imemREN, imemaddr  icache read request and word address (always PC)
//   ihit, imemload     icache hit strobe and returned instruction word
//   stall              hazard-unit freeze of IF/ID and later stages
//   br_taken/br_target taken branch from EX (wins over jmp)
//   jmp/jmp_target     J/JAL/JR from ID
//   halt               HALT committed; fetch stops until reset
//   ifinstr            instruction presented to IF/ID
//   ifJALjump_addr     PC+4 of the presented instruction
//   ifW, ifRST         IF/ID write enable and synchronous flush
//   pc                 current PC, for debug visibility
module fetch_unit #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        nRST,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   input  logic        ihit,
   input  logic [31:0] imemload,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jmp,
   input  logic [31:0] jmp_target,
   input  logic        halt,
   output logic [31:0] ifinstr,
   output logic [31:0] ifJALjump_addr,
   output logic        ifW,
   output logic        ifRST,
   output logic [31:0] pc
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_hbuf;
   logic [31:0] r_hpc4;

   state_t      w_state_nxt;
   logic [31:0] w_pc_nxt;
   logic        w_buf_ld;
   logic        w_redirect;
   logic [31:0] w_target;
   logic [31:0] w_pc4;
   logic [31:0] w_instr;
   logic [31:0] w_jal;

   // The low two bits of any target are dropped so the PC stays word aligned.
   assign w_redirect = !stall && (br_taken || jmp);
   assign w_target   = {(br_taken ? br_target[31:2] : jmp_target[31:2]), 2'b00};
   assign w_pc4      = r_pc + 32'd4;

   assign imemaddr = r_pc;
   assign pc       = r_pc;

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_buf_ld    = 1'b0;
      imemREN     = 1'b0;
      ifW         = 1'b0;
      ifRST       = 1'b0;
      w_instr     = '0;
      w_jal       = '0;
      unique case (r_state)
         FETCH: begin
            imemREN = 1'b1;
            w_instr = imemload;
            w_jal   = w_pc4;
            if (halt) begin
               ifW         = 1'b1;
               ifRST       = 1'b1;
               w_state_nxt = HALTED;
            end else if (w_redirect) begin
               // A hit arriving in the same cycle is dropped.
               ifW      = 1'b1;
               ifRST    = 1'b1;
               w_pc_nxt = w_target;
            end else if (ihit && !stall) begin
               ifW      = 1'b1;
               w_pc_nxt = w_pc4;
            end else if (ihit) begin
               w_buf_ld    = 1'b1;
               w_state_nxt = HOLD;
            end
         end
         HOLD: begin
            w_instr = r_hbuf;
            w_jal   = r_hpc4;
            if (halt) begin
               ifW         = 1'b1;
               ifRST       = 1'b1;
               w_state_nxt = HALTED;
            end else if (!stall) begin
               ifW         = 1'b1;
               ifRST       = w_redirect;
               w_pc_nxt    = w_redirect ? w_target : w_pc4;
               w_state_nxt = FETCH;
            end
         end
         default: begin
            // HALTED: everything idle and the PC frozen until reset.
         end
      endcase
   end

   // A flushed IF/ID entry carries zeros.
   assign ifinstr        = ifRST ? '0 : w_instr;
   assign ifJALjump_addr = ifRST ? '0 : w_jal;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= FETCH;
         r_pc    <= PC_INIT;
         r_hbuf  <= '0;
         r_hpc4  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         if (w_buf_ld) begin
            r_hbuf <= imemload;
            r_hpc4 <= w_pc4;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam logic [31:0] PC_INIT = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jmp;
   logic [31:0] jmp_target;
   logic        halt;
   logic [31:0] ifinstr;
   logic [31:0] ifJALjump_addr;
   logic        ifW;
   logic        ifRST;
   logic [31:0] pc;

   int n_checks = 0;
   int n_errors = 0;

   fetch_unit #(.PC_INIT(PC_INIT)) dut (
      .CLK(clk), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
      .ihit(ihit), .imemload(imemload), .stall(stall),
      .br_taken(br_taken), .br_target(br_target),
      .jmp(jmp), .jmp_target(jmp_target), .halt(halt),
      .ifinstr(ifinstr), .ifJALjump_addr(ifJALjump_addr),
      .ifW(ifW), .ifRST(ifRST), .pc(pc)
   );

   always #5 clk = ~clk;

   // Reference model: what fetch currently "has" in terms of the pipeline story.
   logic [31:0] m_pc;
   bit          m_waiting;   // a word was returned but the pipe was frozen
   logic [31:0] m_word;
   logic [31:0] m_link;
   bit          m_stopped;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc      = PC_INIT;
      m_waiting = 0;
      m_word    = 0;
      m_link    = 0;
      m_stopped = 0;
   endtask

   task automatic idle_inputs();
      ihit = 0; imemload = 0; stall = 0; br_taken = 0; br_target = 0;
      jmp = 0; jmp_target = 0; halt = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      nRST = 1'b0;
      model_reset();
      #2;
      check("rst_pc", pc, PC_INIT);
      check("rst_ifW", {31'd0, ifW}, 32'd0);
      check("rst_ifRST", {31'd0, ifRST}, 32'd0);
      #1 nRST = 1'b1;
      @(posedge clk); #1;
   endtask

   // One clock: apply inputs, compare against the model mid-cycle, advance.
   task automatic step(input bit h, input logic [31:0] ld, input bit st,
                       input bit b, input logic [31:0] bt,
                       input bit j, input logic [31:0] jt, input bit hl);
      bit          e_ren, e_w, e_rst, e_cmp_data;
      logic [31:0] e_instr, e_link, nxt_pc, tgt;
      bit          redir;
      ihit = h; imemload = ld; stall = st; br_taken = b; br_target = bt;
      jmp = j; jmp_target = jt; halt = hl;
      redir  = !st && (b || j);
      tgt    = b ? bt : jt;
      tgt    = tgt - (tgt % 4);
      nxt_pc = m_pc;
      e_w = 0; e_rst = 0; e_instr = 0; e_link = 0; e_cmp_data = 0;
      e_ren = !m_stopped && !m_waiting;
      if (m_stopped) begin
         // frozen
      end else if (hl) begin
         e_w = 1; e_rst = 1; e_cmp_data = 1;
         m_stopped = 1;
      end else if (m_waiting) begin
         e_instr = m_word; e_link = m_link; e_cmp_data = 1;
         if (!st) begin
            e_w = 1;
            if (redir) begin
               e_rst = 1; e_instr = 0; e_link = 0; nxt_pc = tgt;
            end else begin
               nxt_pc = m_pc + 4;
            end
            m_waiting = 0;
         end
      end else if (redir) begin
         e_w = 1; e_rst = 1; e_cmp_data = 1; nxt_pc = tgt;
      end else if (h && !st) begin
         e_w = 1; e_cmp_data = 1; e_instr = ld; e_link = m_pc + 4;
         nxt_pc = m_pc + 4;
      end else if (h) begin
         m_waiting = 1; m_word = ld; m_link = m_pc + 4;
      end
      #3;
      check("imemaddr", imemaddr, m_pc);
      check("pc", pc, m_pc);
      check("imemREN", {31'd0, imemREN}, {31'd0, e_ren});
      check("ifW", {31'd0, ifW}, {31'd0, e_w});
      check("ifRST", {31'd0, ifRST}, {31'd0, e_rst});
      if (e_cmp_data) begin
         check("ifinstr", ifinstr, e_instr);
         check("ifJAL", ifJALjump_addr, e_link);
      end
      m_pc = nxt_pc;
      @(posedge clk); #1;
   endtask

   initial begin
      nRST = 1'b1;
      idle_inputs();
      #1;
      do_reset();

      // Streaming hits from reset.
      for (int unsigned i = 0; i < 4; i++)
         step(1, 32'h2001_0001 + i * 32'h0001_0001, 0, 0, 0, 0, 0, 0);
      // Misses at PC=0x10, then a hit.
      for (int unsigned i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 32'hAAAA_0010, 0, 0, 0, 0, 0, 0);
      // Get to 0x20 and buffer across a stall.
      for (int unsigned i = 0; i < 3; i++) step(1, 32'h1111_0000 + i, 0, 0, 0, 0, 0, 0);
      step(1, 32'h8C22_0000, 1, 0, 0, 0, 0, 0);
      step(1, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 0);
      step(1, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("after_hold_pc", pc, 32'h24);
      // Redirect priority, then stalled redirect ignored.
      step(1, 32'h5555_5555, 0, 1, 32'h100, 1, 32'h200, 0);
      check("br_prio_pc", pc, 32'h100);
      step(0, 0, 1, 1, 32'h300, 1, 32'h400, 0);
      // Redirect out of HOLD with an unaligned target.
      step(1, 32'h1234_5678, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 32'h43, 0);
      check("hold_redir_pc", pc, 32'h40);
      // Wrap then halt then async reset.
      step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
      step(1, 32'h0BAD_F00D, 0, 0, 0, 0, 0, 0);
      check("wrap_pc", pc, 32'h0);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      for (int unsigned i = 0; i < 3; i++) step(1, 32'h7777_7777, 0, 1, 32'h80, 0, 0, 0);
      do_reset();

      // Randomized traffic including halts and resets in any state.
      for (int unsigned i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0 || (m_stopped && $urandom_range(0, 5) == 0))
            do_reset();
         else
            step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 11) == 0, $urandom,
                 $urandom_range(0, 11) == 0, $urandom,
                 $urandom_range(0, 149) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
